// File: rtl/seg_display_scan_if.sv
// Display-path bundle between the CPU write-back producer and the 7-segment scanner.
// The producer (master) drives value/strobe/blanking; the scanner (slave) drives the display pins.
interface seg_display_scan_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        blank_lead;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;
  logic [31:0] shown_value;

  modport master (
    output data_in, data_valid, blank_lead,
    input  an, seg, frame_tick, shown_value
  );

  modport slave (
    input  data_in, data_valid, blank_lead,
    output an, seg, frame_tick, shown_value
  );
endinterface

// File: rtl/seg_display_scan.sv
// 8-digit multiplexed active-low hex display scanner; new values double-buffered and swapped at frame boundaries.
// Outputs registered one cycle behind the slot counters; strobes are always accepted (no backpressure, last write wins).
module seg_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 17
) (
  input logic           clk,
  input logic           clr,
  seg_display_scan_if.slave bus
);

  typedef enum logic {S_GAP, S_ON} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [31:0]      disp_q, disp_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick_q, tick_d;

  logic       slot_end;
  logic       boundary;
  logic       lead_zero;
  logic [3:0] nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + CNT_W'(1);
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    an_d      = 8'hFF;
    seg_d     = 7'h7F;

    slot_end  = (div_q == CNT_W'(REFRESH_DIV - 1));
    boundary  = slot_end && (idx_q == 3'd7);
    tick_d    = boundary;
    nibble    = disp_q[{idx_q, 2'b00} +: 4];
    // Digit idx and everything above it is zero: treat the whole slot as a gap.
    lead_zero = bus.blank_lead && (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);

    if (slot_end) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end

    case (state_q)
      S_GAP:   if (div_q == CNT_W'(GAP_CYCLES - 1)) state_d = S_ON;
      default: if (slot_end) state_d = S_GAP;
    endcase

    if (state_q == S_ON && !lead_zero) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = hex7(nibble);
    end

    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    // A strobe on the boundary cycle lands in the shadow after the old shadow swaps out.
    if (bus.data_valid) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_GAP;
      div_q     <= '0;
      idx_q     <= 3'd0;
      shadow_q  <= 32'd0;
      pending_q <= 1'b0;
      disp_q    <= 32'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_tick  = tick_q;
  assign bus.shown_value = disp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with an 8-cycle slot, 2-cycle gap (64-cycle frame).
module tb_seg_display_scan;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   k = 0;

  logic [31:0] m_shown = 32'd0;
  logic [31:0] m_shadow = 32'd0;
  logic        m_pend = 1'b0;

  seg_display_scan_if bus ();

  seg_display_scan #(.REFRESH_DIV(8), .GAP_CYCLES(2), .CNT_W(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // One clock: predict the registered outputs from the pre-edge slot position, then compare.
  task automatic tick();
    logic [7:0]  ea;
    logic [6:0]  es;
    logic        eft;
    logic [31:0] v;
    int d, i;
    d   = k % 8;
    i   = (k / 8) % 8;
    v   = m_shown;
    ea  = 8'hFF;
    es  = 7'h7F;
    eft = 1'b0;
    if (!clr) begin
      eft = (k % 64 == 63);
      if (d >= 2 && !(bus.blank_lead && i > 0 && (v >> (4 * i)) == 32'd0)) begin
        ea = ~(8'b1 << i);
        es = hex7(v[4*i +: 4]);
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      k = 0; m_shown = 32'd0; m_shadow = 32'd0; m_pend = 1'b0;
    end else begin
      if (k % 64 == 63 && m_pend) begin
        m_shown = m_shadow;
        m_pend  = 1'b0;
      end
      if (bus.data_valid) begin
        m_shadow = bus.data_in;
        m_pend   = 1'b1;
      end
      k++;
    end
    check("an", {24'd0, bus.an}, {24'd0, ea});
    check("seg", {25'd0, bus.seg}, {25'd0, es});
    check("frame_tick", {31'd0, bus.frame_tick}, {31'd0, eft});
    check("shown_value", bus.shown_value, m_shown);
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic strobe(input logic [31:0] v);
    bus.data_valid = 1'b1;
    bus.data_in    = v;
    tick();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    // Reset with a simultaneous strobe: clear must win.
    clr            = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 32'hDEADBEEF;
    bus.blank_lead = 1'b0;
    tick();
    tick();
    bus.data_valid = 1'b0;
    clr            = 1'b0;
    check("rst_an", {24'd0, bus.an}, 32'h0000_00FF);
    check("rst_seg", {25'd0, bus.seg}, 32'h0000_007F);
    check("rst_shown", bus.shown_value, 32'd0);

    // Idle scan.
    run_to(3);
    check("idle_an0", {24'd0, bus.an}, 32'h0000_00FE);
    check("idle_seg0", {25'd0, bus.seg}, 32'h0000_0040);
    run_to(64);
    check("idle_tick", {31'd0, bus.frame_tick}, 32'd1);
    run_to(65);
    check("idle_tick_off", {31'd0, bus.frame_tick}, 32'd0);
    run_to(200);
    check("idle_no_stale", bus.shown_value, 32'd0);

    clr = 1'b1;
    tick();
    clr = 1'b0;

    // First value appears only at the first boundary.
    run_to(5);
    strobe(32'h12345678);
    run_to(63);
    check("t2_pre", bus.shown_value, 32'd0);
    run_to(64);
    check("t2_post", bus.shown_value, 32'h12345678);
    run_to(67);
    check("t2_an_d0", {24'd0, bus.an}, 32'h0000_00FE);
    check("t2_seg_d0", {25'd0, bus.seg}, 32'h0000_0000);
    run_to(75);
    check("t2_an_d1", {24'd0, bus.an}, 32'h0000_00FD);
    check("t2_seg_d1", {25'd0, bus.seg}, 32'h0000_0078);
    run_to(123);
    check("t2_an_d7", {24'd0, bus.an}, 32'h0000_007F);
    check("t2_seg_d7", {25'd0, bus.seg}, 32'h0000_0079);

    // Back-to-back strobes: last wins.
    run_to(130);
    strobe(32'hAAAAAAAA);
    strobe(32'hBBBBBBBB);
    run_to(192);
    check("t4_last_wins", bus.shown_value, 32'hBBBBBBBB);
    run_to(256);

    // Strobe on the boundary cycle while another value is pending.
    run_to(260);
    strobe(32'hDDDDDDDD);
    run_to(319);
    strobe(32'hCCCCCCCC);
    check("t5_swap_old", bus.shown_value, 32'hDDDDDDDD);
    run_to(383);
    check("t5_hold", bus.shown_value, 32'hDDDDDDDD);
    run_to(384);
    check("t5_next", bus.shown_value, 32'hCCCCCCCC);

    // Leading-zero blanking.
    run_to(385);
    bus.blank_lead = 1'b1;
    run_to(390);
    strobe(32'h0);
    run_to(448);
    check("t3_zero_val", bus.shown_value, 32'd0);
    run_to(451);
    check("t3_zero_an0", {24'd0, bus.an}, 32'h0000_00FE);
    check("t3_zero_seg0", {25'd0, bus.seg}, 32'h0000_0040);
    run_to(459);
    check("t3_zero_an1", {24'd0, bus.an}, 32'h0000_00FF);
    run_to(500);
    strobe(32'h000000A0);
    run_to(512);
    check("t3_a0_val", bus.shown_value, 32'h000000A0);
    run_to(515);
    check("t3_a0_an0", {24'd0, bus.an}, 32'h0000_00FE);
    check("t3_a0_seg0", {25'd0, bus.seg}, 32'h0000_0040);
    run_to(523);
    check("t3_a0_an1", {24'd0, bus.an}, 32'h0000_00FD);
    check("t3_a0_seg1", {25'd0, bus.seg}, 32'h0000_0008);
    run_to(531);
    check("t3_a0_an2", {24'd0, bus.an}, 32'h0000_00FF);
    run_to(576);

    // Mid-frame clear with a value pending and a strobe in the same cycle.
    run_to(580);
    strobe(32'h11111111);
    run_to(600);
    clr            = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 32'h22222222;
    tick();
    clr            = 1'b0;
    bus.data_valid = 1'b0;
    check("t6_an", {24'd0, bus.an}, 32'h0000_00FF);
    check("t6_shown", bus.shown_value, 32'd0);
    run_to(200);
    check("t6_dropped", bus.shown_value, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
